// File: rtl/timer_alarm_pkg.sv
// rtl/timer_alarm_pkg.sv - shared types and defaults for the timer alarm
// Purpose: state encoding and default counter width shared by the top level
//          and the down-counter.
// Ports:   none (package).
package timer_alarm_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/timer_alarm_counter.sv
// rtl/timer_alarm_counter.sv - loadable saturating down-counter with is-one detect
// Purpose: holds the remaining tick count; load wins over decrement, and the
//          count never goes below zero.
// Ports:   clock, reset (async active-low)
//          load, load_val  - load a new count
//          dec             - decrement by one (held at zero)
//          count           - current count
//          is_one          - count equals one (next decrement expires)
module timer_alarm_counter
  import timer_alarm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == ONE);

endmodule

// File: rtl/timer_alarm.sv
// rtl/timer_alarm.sv - tick-driven countdown alarm with held interrupt
// Purpose: processor loads a delay in timer ticks; the block counts tick_in
//          pulses down and raises irq on expiry, held until irq_ack.
// Ports:   clock, reset (async active-low)
//          tick_in             - one-cycle timer pulse
//          wr_en, wr_data      - delay load strobe and value
//          irq_ack             - interrupt acknowledge pulse
//          irq, busy           - alarm expired / counting
//          remaining           - current remaining tick count
//          overrun             - only with TIMER_ALARM_AUTORELOAD_EN
// Options: TIMER_ALARM_AUTORELOAD_EN - periodic reload from the last written
//          delay, with overrun flag when an expiry hits an unacknowledged irq.
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             irq_ack,
  output logic             irq,
  output logic             busy,
`ifdef TIMER_ALARM_AUTORELOAD_EN
  output logic             overrun,
`endif
  output logic [WIDTH-1:0] remaining
);

  state_e           state_q, state_d;
  logic             irq_q, irq_d;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dec;
  logic             accept;
  logic             is_one;
  logic [WIDTH-1:0] count;

`ifdef TIMER_ALARM_AUTORELOAD_EN
  logic [WIDTH-1:0] period_q, period_d;
  logic             overrun_q, overrun_d;
  logic             reload;
`endif

  timer_alarm_counter #(.WIDTH(WIDTH)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .count    (count),
    .is_one   (is_one)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = wr_data;
    dec      = 1'b0;
    accept   = 1'b0;
`ifdef TIMER_ALARM_AUTORELOAD_EN
    reload   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (wr_en) accept = 1'b1;
      end
      ARMED: begin
        // A write restarts the count and swallows any same-cycle tick.
        if (wr_en) begin
          accept = 1'b1;
        end else if (tick_in) begin
          if (is_one) begin
`ifdef TIMER_ALARM_AUTORELOAD_EN
            // ARMED is only reached with a non-zero period, so reload is safe.
            reload   = 1'b1;
            load     = 1'b1;
            load_val = period_q;
`else
            dec      = 1'b1;
            state_d  = FIRED;
`endif
          end else begin
            dec = 1'b1;
          end
        end
      end
      FIRED: begin
        // Writes are only honoured together with the acknowledge.
        if (irq_ack) begin
          state_d = IDLE;
          if (wr_en) accept = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      load     = 1'b1;
      load_val = wr_data;
      state_d  = (wr_data == '0) ? FIRED : ARMED;
    end

    irq_d = (state_d == FIRED);

`ifdef TIMER_ALARM_AUTORELOAD_EN
    period_d  = accept ? wr_data : period_q;
    overrun_d = overrun_q && !irq_ack;
    if (irq_q && !irq_ack) irq_d = 1'b1;
    if (reload) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) overrun_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

`ifdef TIMER_ALARM_AUTORELOAD_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  assign irq       = irq_q;
  assign busy      = (state_q == ARMED);
  assign remaining = count;

endmodule

// File: tb/tb_timer_alarm.sv
// tb/tb_timer_alarm.sv - self-checking bench for timer_alarm
module tb_timer_alarm;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         tick_in;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         irq_ack;
  logic         irq;
  logic         busy;
  logic [W-1:0] remaining;
`ifdef TIMER_ALARM_AUTORELOAD_EN
  logic         overrun;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  timer_alarm #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (tick_in),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .busy      (busy),
`ifdef TIMER_ALARM_AUTORELOAD_EN
    .overrun   (overrun),
`endif
    .remaining (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         tick;
    logic         wr;
    logic [W-1:0] data;
    logic         ack;
    logic         e_irq;
    logic         e_busy;
    logic [W-1:0] e_rem;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic tick, input logic wr, input logic [W-1:0] data,
                              input logic ack, input logic e_irq, input logic e_busy,
                              input logic [W-1:0] e_rem);
    vec_t v;
    v.tick = tick; v.wr = wr; v.data = data; v.ack = ack;
    v.e_irq = e_irq; v.e_busy = e_busy; v.e_rem = e_rem;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic cyc(input logic tick, input logic wr, input logic [W-1:0] data, input logic ack);
    tick_in = tick; wr_en = wr; wr_data = data; irq_ack = ack;
    @(negedge clock);
    tick_in = 1'b0; wr_en = 1'b0; wr_data = '0; irq_ack = 1'b0;
  endtask

  task automatic check_out(input string name, input logic e_irq, input logic e_busy,
                           input logic [W-1:0] e_rem);
    check({name, ".irq"},  {31'd0, irq},  {31'd0, e_irq});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    check({name, ".rem"},  remaining,     e_rem);
  endtask

  initial begin
    logic held;
    reset = 1'b0; tick_in = 1'b0; wr_en = 1'b0; wr_data = '0; irq_ack = 1'b0;
    repeat (3) @(negedge clock);
    check_out("reset", 1'b0, 1'b0, '0);
    reset = 1'b1;
    @(negedge clock);

`ifndef TIMER_ALARM_AUTORELOAD_EN
    // One-shot table, applied from IDLE.
    add(0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 3,  0, 0, 1, 3);
    add(1, 0, 0,  0, 0, 1, 2);
    add(1, 0, 0,  0, 0, 1, 1);
    add(1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 5,  0, 0, 1, 5);
    add(1, 0, 0,  0, 0, 1, 4);
    add(1, 0, 0,  0, 0, 1, 3);
    add(1, 1, 10, 0, 0, 1, 10);
    add(0, 0, 0,  1, 0, 1, 10);
    for (int i = 9; i >= 1; i--) add(1, 0, 0, 0, 0, 1, W'(i));
    add(1, 0, 0,  0, 1, 0, 0);
    add(0, 1, 4,  0, 1, 0, 0);
    add(1, 0, 0,  0, 1, 0, 0);
    add(0, 1, 2,  1, 0, 1, 2);
    add(1, 0, 0,  0, 0, 1, 1);
    add(1, 0, 0,  0, 1, 0, 0);
    add(1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].tick, vecs[i].wr, vecs[i].data, vecs[i].ack);
      check_out($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_busy, vecs[i].e_rem);
    end

    // irq held for 100 cycles with ticks arriving and no acknowledge.
    cyc(0, 1, 0, 0);
    held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, 0, 0);
      if (!irq || remaining != '0) held = 1'b0;
    end
    check("hold100", {31'd0, held}, 32'd1);
    cyc(0, 0, 0, 1);
    check_out("hold_ack", 1'b0, 1'b0, '0);
`else
    // Periodic reload with overrun.
    cyc(0, 1, 2, 0);
    check_out("ar_load", 1'b0, 1'b1, 2);
    cyc(1, 0, 0, 0);
    check_out("ar_t1", 1'b0, 1'b1, 1);
    cyc(1, 0, 0, 0);
    check_out("ar_t2", 1'b1, 1'b1, 2);
    check("ar_t2.ovr", {31'd0, overrun}, 32'd0);
    cyc(1, 0, 0, 0);
    check_out("ar_t3", 1'b1, 1'b1, 1);
    cyc(1, 0, 0, 0);
    check_out("ar_t4", 1'b1, 1'b1, 2);
    check("ar_t4.ovr", {31'd0, overrun}, 32'd1);
    cyc(0, 0, 0, 1);
    check_out("ar_ack", 1'b0, 1'b1, 2);
    check("ar_ack.ovr", {31'd0, overrun}, 32'd0);
    // Zero write makes it one-shot.
    cyc(0, 1, 0, 0);
    check_out("ar_zero", 1'b1, 1'b0, 0);
    cyc(1, 0, 0, 0);
    check_out("ar_zero_tick", 1'b1, 1'b0, 0);
    cyc(0, 0, 0, 1);
    check_out("ar_zero_ack", 1'b0, 1'b0, 0);
`endif

    // Maximum delay decrements without wrapping.
    cyc(0, 1, 32'hFFFF_FFFF, 0);
    check_out("max_load", 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc(1, 0, 0, 0);
    check_out("max_tick", 1'b0, 1'b1, 32'hFFFF_FFFE);

    // Asynchronous reset in the middle of a count.
    cyc(0, 1, 7, 0);
    check_out("pre_rst", 1'b0, 1'b1, 7);
    #2 reset = 1'b0;
    #1 check_out("async_rst", 1'b0, 1'b0, '0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_out("post_rst", 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
